// File: rtl/decode_stage.sv
// Decode stage: classifies instructions, resolves register hazards with a per-register pending scoreboard, registers operands.
// Latency: exactly 1 cycle from issue (in_valid && in_ready) to out_valid.
// Backpressure: in_ready drops on a full output slot, a hazard, flush or reset; the output register holds while out_ready=0.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rf_addr_r1,
  output logic [ADDR_W-1:0] rf_addr_r2,
  input  logic [DATA_W-1:0] rf_data_r1,
  input  logic [DATA_W-1:0] rf_data_r2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_we,
  output logic [15:0]       stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              we;
  } hdr_t;

  logic [3:0]        dec_op;
  logic [ADDR_W-1:0] dec_rd;
  logic [ADDR_W-1:0] dec_rs;
  logic [ADDR_W-1:0] dec_rt;
  logic              dec_reads_rs;
  logic              dec_reads_rt;
  logic              dec_we;
  logic              dec_imm;
  hdr_t              dec_hdr;
  hdr_t              out_hdr;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              hazard;
  logic              slot_free;
  logic              issue;

  assign dec_op = in_instr[15:12];
  assign dec_rd = in_instr[11:8];
  assign dec_rs = in_instr[7:4];
  assign dec_rt = in_instr[3:0];

  assign rf_addr_r1 = dec_rs;
  assign rf_addr_r2 = dec_rt;

  // Opcode class decode: which sources are read, whether rd is written, whether B is the immediate
  always_comb begin
    dec_reads_rs = 1'b0;
    dec_reads_rt = 1'b0;
    dec_we       = 1'b0;
    dec_imm      = 1'b0;
    case (dec_op)
      4'h8: begin dec_reads_rs = 1'b1; dec_we = 1'b1; dec_imm = 1'b1; end
      4'h9: begin dec_reads_rs = 1'b1; dec_reads_rt = 1'b1; dec_imm = 1'b1; end
      4'hA: begin dec_reads_rs = 1'b1; dec_we = 1'b1; dec_imm = 1'b1; end
      4'hB: begin dec_reads_rs = 1'b1; dec_reads_rt = 1'b1; end
      4'hC, 4'hD, 4'hE, 4'hF: begin end
      default: begin dec_reads_rs = 1'b1; dec_reads_rt = 1'b1; dec_we = 1'b1; end
    endcase
  end

  // Operand assembly for the output register; the 4-bit immediate sits in the rt field
  always_comb begin
    dec_hdr    = '0;
    dec_hdr.op = dec_op;
    dec_hdr.rd = dec_rd;
    dec_hdr.a  = rf_data_r1;
    dec_hdr.b  = dec_imm ? {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]} : rf_data_r2;
    dec_hdr.we = dec_we;
  end

  assign hazard    = in_valid && ((dec_reads_rs && pending[dec_rs]) ||
                                  (dec_reads_rt && pending[dec_rt]) ||
                                  (dec_we && pending[dec_rd]));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush && !rst;
  assign issue     = in_valid && in_ready;

  // Scoreboard next state: clears from writeback and flush first, so a same-cycle issue set wins
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && out_hdr.we) pending_nxt[out_hdr.rd] = 1'b0;
    if (issue && dec_we) pending_nxt[dec_rd] = 1'b1;
  end

  // Pending register state
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Output register: flush squashes, issue loads, a free slot with no issue becomes a bubble, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hdr   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_hdr   <= dec_hdr;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles lost to hazards
  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end

  assign out_op = out_hdr.op;
  assign out_rd = out_hdr.rd;
  assign out_a  = out_hdr.a;
  assign out_b  = out_hdr.b;
  assign out_we = out_hdr.we;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: random and directed instruction streams against a behavioural scoreboard model.
// Expected outputs are queued on modelled issue and popped by an independent monitor on consumption.
// Fixed cycle counts only; no open-ended waits.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [3:0]  rf_addr_r1;
  logic [3:0]  rf_addr_r2;
  logic [15:0] rf_data_r1;
  logic [15:0] rf_data_r2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        out_we;
  logic [15:0] stall_cnt;

  decode_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2), .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2),
    .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_we(out_we), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        m_known = 1'b0;
  logic        m_v = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [15:0] m_cnt = '0;
  bit          pend[16];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Instruction-set rules, stated per opcode class
  function automatic bit uses_rs(input logic [3:0] op); return op <= 4'hB; endfunction
  function automatic bit uses_rt(input logic [3:0] op); return op <= 4'h7 || op == 4'h9 || op == 4'hB; endfunction
  function automatic bit writes(input logic [3:0] op);  return op <= 4'h7 || op == 4'h8 || op == 4'hA; endfunction
  function automatic bit has_imm(input logic [3:0] op); return op == 4'h8 || op == 4'h9 || op == 4'hA; endfunction

  // One clock cycle: check registered state, drive inputs, check combinational outputs, advance the model
  task automatic step(input logic iv, input logic [15:0] ins, input logic ordy, input logic wbe,
                      input logic [3:0] wa, input logic fl, input logic r,
                      input logic [15:0] d1, input logic [15:0] d2);
    logic [3:0] op, rd, rs, rt;
    logic slot, haz, exp_rdy, iss;
    exp_t e;
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", out_valid, m_v);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
    in_valid = iv; in_instr = ins; out_ready = ordy; wb_en = wbe; wb_addr = wa;
    flush = fl; rst = r; rf_data_r1 = d1; rf_data_r2 = d2;
    #1;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    chk("rf_addr_r1", rf_addr_r1, rs);
    chk("rf_addr_r2", rf_addr_r2, rt);
    if (r) begin
      chk("in_ready_in_reset", in_ready, 0);
      m_v = 0; m_we = 0; m_rd = 0; m_cnt = 0;
      foreach (pend[i]) pend[i] = 0;
      exp_q.delete();
      m_known = 1;
    end else begin
      slot    = !m_v || ordy;
      haz     = iv && ((uses_rs(op) && pend[rs]) || (uses_rt(op) && pend[rt]) || (writes(op) && pend[rd]));
      exp_rdy = slot && !haz && !fl;
      chk("in_ready", in_ready, exp_rdy);
      iss = iv && exp_rdy;
      if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (wbe) pend[wa] = 0;
      if (fl && m_v) begin
        if (m_we) pend[m_rd] = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (iss) begin
        e.op = op; e.rd = rd; e.a = d1; e.we = writes(op);
        e.b  = has_imm(op) ? {{12{rt[3]}}, rt} : d2;
        exp_q.push_back(e);
        if (writes(op)) pend[rd] = 1;
        m_we = writes(op); m_rd = rd;
      end
      m_v = fl ? 1'b0 : iss ? 1'b1 : slot ? 1'b0 : m_v;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_op"}, out_op, 0);
    chk({tag, "_out_rd"}, out_rd, 0);
    chk({tag, "_out_a"}, out_a, 0);
    chk({tag, "_out_b"}, out_b, 0);
    chk({tag, "_out_we"}, out_we, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  // Monitor: every consumed output must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (m_known && !rst && !flush && out_valid && out_ready) begin
        chk("scoreboard_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_op", out_op, e.op);
          chk("out_rd", out_rd, e.rd);
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_we", out_we, e.we);
        end
      end
    end
  end

  initial begin
    logic [15:0] ins;
    rst = 1; in_valid = 0; in_instr = 0; out_ready = 0; wb_en = 0; wb_addr = 0; flush = 0;
    rf_data_r1 = 0; rf_data_r2 = 0;

    step(1, 16'hA10E, 1, 1, 4'd1, 1, 1, 16'h1234, 16'h5678);
    after_edge();
    chk_zero("reset");

    // ADDI r1,r0,#-2
    step(1, 16'hA10E, 1, 0, 0, 0, 0, 16'h0005, 16'h7777);
    after_edge();
    chk("addi_valid", out_valid, 1);
    chk("addi_op", out_op, 4'hA);
    chk("addi_rd", out_rd, 4'd1);
    chk("addi_a", out_a, 16'h0005);
    chk("addi_b", out_b, 16'hFFFE);
    chk("addi_we", out_we, 1);
    step(1, 16'h0312, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("raw_r1_stall", in_ready, 0);
    step(1, 16'h0312, 1, 1, 4'd1, 0, 0, 16'h0, 16'h0);
    chk("wb_same_cycle_stall", in_ready, 0);
    step(1, 16'h0312, 1, 0, 0, 0, 0, 16'h0101, 16'h0202);
    chk("after_wb_issue", in_ready, 1);

    // LD r2 then ADD r3,r2,r4 waits for writeback of r2
    step(1, 16'h8250, 1, 1, 4'd3, 0, 0, 16'h0303, 16'h0404);
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0324, 1, (i == 3), 4'd2, 0, 0, 16'h0, 16'h0);
      chk("ld_use_stall", in_ready, 0);
    end
    step(1, 16'h0324, 1, 0, 0, 0, 0, 16'h1111, 16'h2222);
    chk("ld_use_issue", in_ready, 1);
    after_edge();
    chk("stall_cnt_ld_use", stall_cnt, 16'd6);

    // Output held under backpressure
    for (int i = 0; i < 3; i++) begin
      step(1, 16'hC000, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      chk("hold_in_ready", in_ready, 0);
      after_edge();
      chk("hold_valid", out_valid, 1);
      chk("hold_op", out_op, 4'h0);
      chk("hold_rd", out_rd, 4'd3);
      chk("hold_a", out_a, 16'h1111);
      chk("hold_b", out_b, 16'h2222);
    end
    step(1, 16'hC000, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("hold_release", in_ready, 1);

    // Flush of ADDI r5 releases r5
    step(1, 16'hA501, 1, 0, 0, 0, 0, 16'h0055, 16'h0);
    step(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0, 16'h0);
    after_edge();
    chk("flush_valid", out_valid, 0);
    step(1, 16'h0655, 1, 0, 0, 0, 0, 16'h0666, 16'h0777);
    chk("flush_releases_r5", in_ready, 1);

    // Same-cycle writeback and issue on r6: set wins
    step(0, 16'h0000, 1, 1, 4'd6, 0, 0, 16'h0, 16'h0);
    step(1, 16'hA600, 1, 1, 4'd6, 0, 0, 16'h0606, 16'h0);
    chk("r6_writer_issue", in_ready, 1);
    step(1, 16'h0866, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("r6_set_wins", in_ready, 0);

    // Flush of r7 writer plus writeback of r6 in one cycle
    step(1, 16'hA700, 1, 0, 0, 0, 0, 16'h0707, 16'h0);
    step(0, 16'h0000, 0, 1, 4'd6, 1, 0, 16'h0, 16'h0);
    step(1, 16'h0967, 1, 0, 0, 0, 0, 16'h0909, 16'h0A0A);
    chk("flush_and_wb_clear", in_ready, 1);

    // Random traffic over a small register window so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      ins = {4'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      step(($urandom % 10) < 7, ins, ($urandom % 10) < 7, ($urandom % 10) < 3, 4'($urandom_range(0, 3)),
           ($urandom % 20) == 0, ($urandom % 100) == 0, 16'($urandom), 16'($urandom));
    end

    // Stall counter saturation, then reset mid-stall
    step(0, 16'h0000, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    step(1, 16'h8700, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 65540; i++) step(1, 16'h0177, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    after_edge();
    chk("stall_saturate", stall_cnt, 16'hFFFF);
    step(1, 16'h0177, 1, 1, 4'd7, 1, 1, 16'h0, 16'h0);
    after_edge();
    chk_zero("reset_after_saturate");
    step(1, 16'h0177, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("reset_clears_pending", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, 16, datapath and instruction width.
REQ-002 Parameter ADDR_W, 4, register address width (16 registers).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-007 in_ready  out  1  decode accepts in_instr this cycle.
REQ-008 rf_addr_r1 / rf_addr_r2  out  4 each  register-file read addresses (combinational: in_instr rs / rt).
REQ-009 rf_data_r1 / rf_data_r2  in  16 each  register-file read data, same cycle.
REQ-010 wb_en  in  1  writeback retiring a register write this cycle.
REQ-011 wb_addr  in  4  register being written back.
REQ-012 flush  in  1  squash the instruction held in the output register.
REQ-013 out_valid  out  1  output register holds a decoded instruction.
REQ-014 out_ready  in  1  execute consumes output this cycle.
REQ-015 out_op  out  4  opcode.
REQ-016 out_rd  out  4  destination register.
REQ-017 out_a / out_b  out  16 each  operand A (rf_data_r1) / operand B (rf_data_r2, or sign-extended imm4 for ADDI/LD/ST).
REQ-018 out_we  out  1  instruction writes rd.
REQ-019 stall_cnt  out  16  count of hazard-stall cycles, saturating.

Function
REQ-020 Opcode classes: 0x0-0x7 ALU R-type (reads rs, rt; writes rd); 0x8 LD (reads rs; writes rd); 0x9 ST (reads rs, rt; no write); 0xA ADDI (reads rs; writes rd); 0xB BEQ (reads rs, rt; no write); 0xC-0xF NOP (reads none, writes none).
REQ-021 Scoreboard: 16 pending bits, one per register; a bit set means a write to that register is in flight.
REQ-022 Hazard = in_valid and (any source read by the instruction is pending, or it writes rd and rd is pending).
REQ-023 Output register may load when out_valid=0 or out_ready=1 ("slot free").
REQ-024 in_ready = slot free and no hazard; an instruction issues when in_valid and in_ready.
REQ-025 On issue: output register loads op, rd, a, b, we at the next edge, out_valid=1; latency exactly 1 cycle.
REQ-026 On issue with out_we=1: pending[rd] set at the same edge.
REQ-027 wb_en clears pending[wb_addr] at the edge; the cleared register may issue a dependent read in the following cycle, not in the same one.
REQ-028 Simultaneous wb_en clear and issue set on same register: set wins.
REQ-029 Slot free but no issue: out_valid cleared (bubble).
REQ-030 Slot not free (out_valid=1, out_ready=0): output register holds all fields unchanged.
REQ-031 flush: out_valid cleared at the edge; if the squashed instruction had out_we=1, its pending[rd] is cleared; in_ready forced 0 that cycle (no issue).
REQ-032 flush and wb_en on different registers in the same cycle: both clears apply.
REQ-033 stall_cnt increments by 1 each cycle with in_valid=1 and hazard=1; holds at 0xFFFF.
REQ-034 Register 0 has no special treatment.

Reset
REQ-035 rst at an edge: out_valid=0, out_op=0, out_rd=0, out_a=0, out_b=0, out_we=0, all pending bits=0, stall_cnt=0.
REQ-036 rst overrides issue, wb_en and flush in the same cycle; asserted mid-operation, any in-flight state is discarded.
REQ-037 in_ready=0 during any cycle with rst=1.

Verification
REQ-038 ADDI r1,r0,#-2 (0xA1 0E) with rf_data_r1=0x0005, out_ready=1 -> next cycle out_valid=1, out_op=0xA, out_rd=1, out_a=0x0005, out_b=0xFFFE, out_we=1, pending[1]=1.
REQ-039 Issue LD r2, then ADD r3,r2,r4 -> in_ready=0 and stall_cnt counts each cycle until wb_en with wb_addr=2; ADD issues one cycle after that edge.
REQ-040 out_ready=0 for 3 cycles with out_valid=1 -> all out_* fields stable, in_ready=0, next instruction not lost; issues when out_ready returns 1.
REQ-041 Issue ADDI r5 then flush next cycle -> out_valid=0, pending[5]=0; subsequent instruction reading r5 issues without stall.
REQ-042 Same-cycle wb_en wb_addr=6 and issue of writer to r6 -> pending[6]=1 after the edge.
REQ-043 Drive stall for 65540 cycles -> stall_cnt=0xFFFF; then rst -> all outputs 0 at next edge.
